// File: rtl/rx_line_pkg.sv
// Shared encodings and helpers for the UART line-packet loader.
// The state encoding is also exported on state_dbg for the debugger data word.
package rx_line_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ROW_HI = 3'd1;
  localparam logic [2:0] ST_ROW_LO = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_TERM   = 3'd4;

  localparam logic [7:0] CMD_LINE   = 8'h4C;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_ZERO) && (b <= ASCII_ZERO + 8'd9);
  endfunction

  // Error counter sticks at full scale so a flood of garbage stays visible.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rx_line_writer_if.sv
// Byte stream in from the UART receiver and framebuffer port A out.
// master = the line writer, slave = the environment (receiver + RAM).
interface rx_line_writer_if #(
  parameter int ADDR_WIDTH = 12
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic [ADDR_WIDTH-1:0] ram_address;
  logic [7:0]            ram_data_out;
  logic                  ram_write_enable;
  logic                  ram_clk_enable;

  modport master (
    input  rx_data, rx_valid,
    output ram_address, ram_data_out, ram_write_enable, ram_clk_enable
  );

  modport slave (
    output rx_data, rx_valid,
    input  ram_address, ram_data_out, ram_write_enable, ram_clk_enable
  );
endinterface

// File: rtl/rx_idle_timer.sv
// Loadable down-counter that pulses expired once when a packet stalls.
// A load in the same cycle as expiry wins, so a late byte still counts.
module rx_idle_timer #(
  parameter int unsigned             WIDTH = 16,
  parameter logic [WIDTH-1:0]        TICKS = 16'd1050
) (
  input  logic clk_in,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expired
);

  logic [WIDTH-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= TICKS;
    end else if (enable && count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expired = enable && !load && (count_q == WIDTH'(1));

endmodule

// File: rtl/rx_line_writer.sv
// Parses 'L' + two-digit row + pixel bytes + LF and writes each pixel
// straight into framebuffer port A; counts good lines and bad packets.
module rx_line_writer
  import rx_line_pkg::*;
#(
  parameter int unsigned                          ROWS               = 32,
  parameter int unsigned                          BYTES_PER_LINE     = 128,
  parameter int unsigned                          ADDR_WIDTH         = 12,
  parameter int unsigned                          IDLE_TIMEOUT_WIDTH = 16,
  parameter logic [IDLE_TIMEOUT_WIDTH-1:0]        IDLE_TIMEOUT_TICKS = 16'd1050
) (
  input  logic                clk_in,
  input  logic                reset,
  rx_line_writer_if.master    bus,
  output logic                busy,
  output logic [7:0]          lines_written,
  output logic [7:0]          error_count,
  output logic [2:0]          state_dbg
);

  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam int unsigned IDX_W = $clog2(BYTES_PER_LINE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_LINE - 1);

  logic [2:0]            state_q;
  logic [3:0]            row_hi_q;
  logic [ROW_W-1:0]      row_q;
  logic [IDX_W-1:0]      index_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            data_q;
  logic                  we_q;
  logic [6:0]            row_val;
  logic                  expired;

  // ASCII digits carry their value in the low nibble; max 99 fits in 7 bits.
  assign row_val = 7'(row_hi_q) * 7'd10 + 7'(bus.rx_data[3:0]);

  rx_idle_timer #(
    .WIDTH (IDLE_TIMEOUT_WIDTH),
    .TICKS (IDLE_TIMEOUT_TICKS)
  ) u_idle_timer (
    .clk_in  (clk_in),
    .reset   (reset),
    .load    (bus.rx_valid),
    .enable  (busy),
    .expired (expired)
  );

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      row_hi_q      <= '0;
      row_q         <= '0;
      index_q       <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      we_q          <= 1'b0;
      lines_written <= '0;
      error_count   <= '0;
    end else begin
      we_q <= 1'b0;
      if (bus.rx_valid) begin
        case (state_q)
          ST_IDLE: begin
            if (bus.rx_data == CMD_LINE) state_q <= ST_ROW_HI;
          end
          ST_ROW_HI: begin
            if (is_digit(bus.rx_data)) begin
              row_hi_q <= bus.rx_data[3:0];
              state_q  <= ST_ROW_LO;
            end else begin
              error_count <= sat_inc(error_count);
              state_q     <= ST_IDLE;
            end
          end
          ST_ROW_LO: begin
            if (is_digit(bus.rx_data) && (32'(row_val) < ROWS)) begin
              row_q   <= row_val[ROW_W-1:0];
              index_q <= '0;
              state_q <= ST_DATA;
            end else begin
              error_count <= sat_inc(error_count);
              state_q     <= ST_IDLE;
            end
          end
          ST_DATA: begin
            addr_q  <= ADDR_WIDTH'({row_q, index_q});
            data_q  <= bus.rx_data;
            we_q    <= 1'b1;
            index_q <= index_q + 1'b1;
            if (index_q == LAST_IDX) state_q <= ST_TERM;
          end
          ST_TERM: begin
            if (bus.rx_data == ASCII_LF) lines_written <= lines_written + 8'd1;
            else                         error_count   <= sat_inc(error_count);
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (expired) begin
        error_count <= sat_inc(error_count);
        state_q     <= ST_IDLE;
      end
    end
  end

  assign bus.ram_address      = addr_q;
  assign bus.ram_data_out     = data_q;
  assign bus.ram_write_enable = we_q;
  assign bus.ram_clk_enable   = we_q;
  assign busy                 = (state_q != ST_IDLE);
  assign state_dbg            = state_q;

endmodule

// File: tb/tb_rx_line_writer.sv
// Directed bench for rx_line_writer: packets, row bounds, bad bytes,
// stalls, timer-boundary byte, mid-packet reset and error saturation.
module tb_rx_line_writer;

  localparam int T = 1050;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       busy;
  logic [7:0] lines_written;
  logic [7:0] error_count;
  logic [2:0] state_dbg;
  int         checks = 0;
  int         failures = 0;
  int         wr_count = 0;
  int         wr_base;

  rx_line_writer_if #(.ADDR_WIDTH(12)) bus ();

  rx_line_writer dut (
    .clk_in        (clk_in),
    .reset         (reset),
    .bus           (bus),
    .busy          (busy),
    .lines_written (lines_written),
    .error_count   (error_count),
    .state_dbg     (state_dbg)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) if (bus.ram_write_enable) wr_count++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one strobe; consecutive calls give back-to-back rx_valid.
  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk_in);
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, 32'(state_dbg), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_lines"}, 32'(lines_written), 0);
    check({tag, "_errs"},  32'(error_count), 0);
    check({tag, "_port"},  32'({bus.ram_write_enable, bus.ram_clk_enable,
                                bus.ram_address, bus.ram_data_out}), 0);
  endtask

  // Header + nbytes data bytes (k ^ pat); each write must appear in the very
  // next cycle at row*128+k with both strobes high.
  task automatic send_body(input string tag, input logic [7:0] hi, input logic [7:0] lo,
                           input int row, input logic [7:0] pat, input int nbytes);
    logic [7:0] d;
    send(8'h4C);
    send(hi);
    send(lo);
    for (int k = 0; k < nbytes; k++) begin
      d = 8'(k) ^ pat;
      send(d);
      check(tag, 32'({bus.ram_write_enable, bus.ram_clk_enable, bus.ram_address,
                      bus.ram_data_out}),
            32'({2'b11, 12'(row * 128 + k), d}));
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    idle(3);
    check_reset_vals("reset");
    reset = 1'b0;
    idle(1);

    // Row 05, data 0x00..0x7F (includes 0x0A and 0x4C as plain data).
    wr_base = wr_count;
    send_body("row05_wr", "0", "5", 5, 8'h00, 128);
    check("row05_busy_term", 32'(state_dbg), 4);
    send(8'h0A);
    idle(2);
    check("row05_writes", 32'(wr_count - wr_base), 128);
    check("row05_lines", 32'(lines_written), 1);
    check("row05_errs", 32'(error_count), 0);
    check("row05_idle", 32'({busy, state_dbg}), 0);

    // Stray CR/LF between packets is silently ignored.
    send(8'h0D);
    send(8'h0A);
    idle(2);
    check("stray_errs", 32'({busy, error_count}), 0);

    // Highest legal row: last write lands at 0xFFF, address then holds.
    send_body("row31_wr", "3", "1", 31, 8'hA5, 128);
    send(8'h0A);
    idle(3);
    check("row31_addr_hold", 32'(bus.ram_address), 32'h0FFF);
    check("row31_lines", 32'(lines_written), 2);

    // Row 32 is out of range.
    wr_base = wr_count;
    send(8'h4C); send("3"); send("2");
    idle(3);
    check("row32_writes", 32'(wr_count - wr_base), 0);
    check("row32_errs", 32'(error_count), 1);
    check("row32_idle", 32'(busy), 0);

    // Non-digit row character.
    wr_base = wr_count;
    send(8'h4C); send("A");
    idle(3);
    check("baddig_writes", 32'(wr_count - wr_base), 0);
    check("baddig_errs", 32'({busy, error_count}), 2);

    // Full packet with CR terminator: writes stay, error counted.
    wr_base = wr_count;
    send_body("badterm_wr", "0", "7", 7, 8'h3C, 128);
    send(8'h0D);
    idle(2);
    check("badterm_writes", 32'(wr_count - wr_base), 128);
    check("badterm_errs", 32'(error_count), 3);
    check("badterm_lines", 32'(lines_written), 2);

    // Stall after 10 data bytes: timeout exactly T cycles after the last byte.
    wr_base = wr_count;
    send_body("stall_wr", "1", "0", 10, 8'h00, 10);
    repeat (T - 1) @(negedge clk_in);
    check("stall_before", 32'({busy, state_dbg, error_count}), 32'({1'b1, 3'd3, 8'd3}));
    @(negedge clk_in);
    check("stall_after", 32'({busy, state_dbg, error_count}), 32'({1'b0, 3'd0, 8'd4}));
    idle(1);
    check("stall_writes", 32'(wr_count - wr_base), 10);
    send_body("after_stall_wr", "1", "0", 10, 8'h5A, 128);
    send(8'h0A);
    idle(2);
    check("after_stall_lines", 32'(lines_written), 3);
    check("after_stall_errs", 32'(error_count), 4);

    // A byte arriving on the expiry cycle wins and the packet continues.
    send(8'h4C);
    repeat (T - 1) @(negedge clk_in);
    send("1");
    check("edge_row_lo", 32'(state_dbg), 2);
    send("2");
    for (int k = 0; k < 128; k++) send(8'(k));
    send(8'h0A);
    idle(2);
    check("edge_lines", 32'(lines_written), 4);
    check("edge_errs", 32'(error_count), 4);

    // Reset at byte 60 aborts the packet and clears everything.
    send_body("rst_wr", "2", "0", 20, 8'hFF, 60);
    reset = 1'b1;
    @(negedge clk_in);
    check_reset_vals("midrst");
    reset = 1'b0;
    send_body("post_rst_wr", "0", "3", 3, 8'h11, 128);
    send(8'h0A);
    idle(2);
    check("post_rst_lines", 32'(lines_written), 1);
    check("post_rst_errs", 32'(error_count), 0);

    // 300 malformed packets: the error counter saturates.
    for (int i = 0; i < 300; i++) begin
      send(8'h4C);
      send("A");
      if (i == 254) begin
        idle(1);
        check("sat_255_reached", 32'(error_count), 255);
      end
    end
    idle(2);
    check("sat_errs", 32'(error_count), 255);
    check("sat_lines", 32'(lines_written), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
